// File: rtl/nfu_act_pkg.sv
// Shared encodings and fixed-point helpers for the NFU piecewise-linear activation stage.
package nfu_act_pkg;

    typedef enum logic [1:0] {
        MODE_PWL  = 2'd0,
        MODE_RELU = 2'd1,
        MODE_BYP  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam int unsigned MODE_W = 2;

    // Largest positive value representable in an n-bit signed word.
    function automatic longint sat_hi(input int unsigned n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    // Most negative value representable in an n-bit signed word.
    function automatic longint sat_lo(input int unsigned n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    // Half an LSB of the result, added before the FRAC-bit right shift.
    function automatic longint round_k(input int unsigned frac);
        return 64'sd1 <<< (frac - 1);
    endfunction

endpackage

// File: rtl/nfu_act_pwl_if.sv
// Beat, coefficient-write and result signals of the PWL activation stage.
interface nfu_act_pwl_if #(
    parameter int unsigned N        = 16,
    parameter int unsigned TN       = 16,
    parameter int unsigned SEG_BITS = 4
);
    import nfu_act_pkg::*;

    logic                  i_valid;
    logic [MODE_W-1:0]     i_mode;
    logic [TN*N-1:0]       i_x;
    logic                  i_coef_we;
    logic [SEG_BITS-1:0]   i_coef_addr;
    logic [2*N-1:0]        i_coef_data;
    logic                  o_valid;
    logic [TN*N-1:0]       o_y;
    logic [TN-1:0]         o_sat;

    modport master (
        output i_valid, i_mode, i_x, i_coef_we, i_coef_addr, i_coef_data,
        input  o_valid, o_y, o_sat
    );

    modport slave (
        input  i_valid, i_mode, i_x, i_coef_we, i_coef_addr, i_coef_data,
        output o_valid, o_y, o_sat
    );

endinterface

// File: rtl/nfu_act_pwl_lane.sv
// One lane of the PWL activation: segment index, multiply-round, add-saturate, mode select.
module pwl_lane
    import nfu_act_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter int unsigned FRAC      = 8,
    parameter int unsigned SEG_BITS  = 4,
    parameter int unsigned SEG_SHIFT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                v_in,
    input  logic                v0,
    input  logic                v1,
    input  logic                v2,
    input  logic [N-1:0]        x_in,
    input  mode_e               mode2,
    input  logic [2*N-1:0]      coef1,
    output logic [SEG_BITS-1:0] idx0,
    output logic [N-1:0]        y,
    output logic                sat
);

    localparam int unsigned SEGS = 2 ** SEG_BITS;
    localparam int unsigned PW   = 2 * N;
    localparam int unsigned SW   = 2 * N + 1;

    localparam logic signed [PW-1:0] RND    = PW'(round_k(FRAC));
    localparam logic signed [SW-1:0] SAT_HI = SW'(sat_hi(N));
    localparam logic signed [SW-1:0] SAT_LO = SW'(sat_lo(N));

    logic signed [N-1:0]   x0, x1, x2;
    logic signed [PW-1:0]  pr2;
    logic signed [N-1:0]   b2;

    logic signed [N-1:0]   x_in_s;
    logic signed [N-1:0]   raw_c;
    logic signed [N:0]     idx_wide_c;
    logic [SEG_BITS-1:0]   idx_c;
    logic signed [N-1:0]   a_c;
    logic signed [N-1:0]   b_c;
    logic signed [PW-1:0]  prod_c;
    logic signed [PW-1:0]  pr_c;
    logic signed [SW-1:0]  sum_c;
    logic [N-1:0]          pwl_y_c;
    logic                  pwl_sat_c;
    logic [N-1:0]          y_c;
    logic                  sat_c;

    // Segment index from the raw input, recentred and clamped to the table.
    always_comb begin
        x_in_s     = $signed(x_in);
        raw_c      = x_in_s >>> SEG_SHIFT;
        idx_wide_c = $signed((N+1)'(raw_c)) + $signed((N+1)'(SEGS / 2));
        idx_c      = idx_wide_c[SEG_BITS-1:0];
        if (idx_wide_c[N]) begin
            idx_c = '0;
        end else if (idx_wide_c[N-1:0] > N'(SEGS - 1)) begin
            idx_c = SEG_BITS'(SEGS - 1);
        end
    end

    // Full-width product, rounded half-up before dropping FRAC bits.
    always_comb begin
        a_c    = $signed(coef1[2*N-1:N]);
        b_c    = $signed(coef1[N-1:0]);
        prod_c = PW'(x1) * PW'(a_c);
        pr_c   = (prod_c + RND) >>> FRAC;
    end

    // Offset add with saturation, then pick the result for the beat's mode.
    always_comb begin
        sum_c     = SW'(pr2) + SW'(b2);
        pwl_y_c   = sum_c[N-1:0];
        pwl_sat_c = 1'b0;
        if (sum_c > SAT_HI) begin
            pwl_y_c   = {1'b0, {(N-1){1'b1}}};
            pwl_sat_c = 1'b1;
        end else if (sum_c < SAT_LO) begin
            pwl_y_c   = {1'b1, {(N-1){1'b0}}};
            pwl_sat_c = 1'b1;
        end

        y_c   = x2;
        sat_c = 1'b0;
        case (mode2)
            MODE_PWL: begin
                y_c   = pwl_y_c;
                sat_c = pwl_sat_c;
            end
            MODE_RELU: y_c = x2[N-1] ? '0 : x2;
            default:   y_c = x2;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0   <= '0;
            idx0 <= '0;
        end else if (v_in) begin
            x0   <= x_in_s;
            idx0 <= idx_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1 <= '0;
        end else if (v0) begin
            x1 <= x0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x2  <= '0;
            pr2 <= '0;
            b2  <= '0;
        end else if (v1) begin
            x2  <= x1;
            pr2 <= pr_c;
            b2  <= b_c;
        end
    end

    // Results hold between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y   <= '0;
            sat <= 1'b0;
        end else if (v2) begin
            y   <= y_c;
            sat <= sat_c;
        end
    end

endmodule

// File: rtl/nfu_act_pwl.sv
// TN-lane piecewise-linear activation with a shared, runtime-writable coefficient table.
module nfu_act_pwl
    import nfu_act_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter int unsigned FRAC      = 8,
    parameter int unsigned TN        = 16,
    parameter int unsigned SEG_BITS  = 4,
    parameter int unsigned SEG_SHIFT = 8
) (
    input  logic         clk,
    input  logic         rst,
    nfu_act_pwl_if.slave bus
);

    localparam int unsigned SEGS = 2 ** SEG_BITS;

    logic [2*N-1:0]      tbl [SEGS];

    logic                v0, v1, v2, v3;
    mode_e               m0, m1, m2;

    logic [SEG_BITS-1:0] lane_idx  [TN];
    logic [2*N-1:0]      lane_coef [TN];
    logic [N-1:0]        lane_y    [TN];
    logic [TN-1:0]       lane_sat;
    logic [TN*N-1:0]     y_flat_c;

    // Coefficient table is deliberately not reset; software loads it before use.
    always_ff @(posedge clk) begin
        if (bus.i_coef_we) begin
            tbl[bus.i_coef_addr] <= bus.i_coef_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v0 <= bus.i_valid;
            v1 <= v0;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Mode rides alongside the beat so it can change every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0 <= MODE_PWL;
            m1 <= MODE_PWL;
            m2 <= MODE_PWL;
        end else begin
            if (bus.i_valid) m0 <= mode_e'(bus.i_mode);
            if (v0)          m1 <= m0;
            if (v1)          m2 <= m1;
        end
    end

    for (genvar k = 0; k < TN; k++) begin : g_lane
        // Per-lane read port; reading the pre-edge array gives read-before-write.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_coef[k] <= '0;
            end else if (v0) begin
                lane_coef[k] <= tbl[lane_idx[k]];
            end
        end

        pwl_lane #(
            .N         (N),
            .FRAC      (FRAC),
            .SEG_BITS  (SEG_BITS),
            .SEG_SHIFT (SEG_SHIFT)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .v_in  (bus.i_valid),
            .v0    (v0),
            .v1    (v1),
            .v2    (v2),
            .x_in  (bus.i_x[k*N +: N]),
            .mode2 (m2),
            .coef1 (lane_coef[k]),
            .idx0  (lane_idx[k]),
            .y     (lane_y[k]),
            .sat   (lane_sat[k])
        );
    end

    always_comb begin
        y_flat_c = '0;
        for (int k = 0; k < TN; k++) begin
            y_flat_c[k*N +: N] = lane_y[k];
        end
    end

    assign bus.o_valid = v3;
    assign bus.o_y     = y_flat_c;
    assign bus.o_sat   = lane_sat;

endmodule

// File: tb/tb_nfu_act_pwl.sv
// Randomised bench for nfu_act_pwl against an arithmetic reference of the PWL/ReLU/bypass rules.
module tb_nfu_act_pwl;

    localparam int N         = 16;
    localparam int FRAC      = 8;
    localparam int TN        = 16;
    localparam int SEG_BITS  = 4;
    localparam int SEG_SHIFT = 8;
    localparam int SEGS      = 16;
    localparam longint YMAX  = 32767;
    localparam longint YMIN  = -32768;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nfu_act_pwl_if #(.N(N), .TN(TN), .SEG_BITS(SEG_BITS)) bus ();

    nfu_act_pwl #(
        .N(N), .FRAC(FRAC), .TN(TN), .SEG_BITS(SEG_BITS), .SEG_SHIFT(SEG_SHIFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors;
    int miscompares;

    int ca [SEGS];
    int cb [SEGS];

    logic              beat_v [64];
    logic [1:0]        beat_m [64];
    logic [TN*N-1:0]   beat_x [64];
    logic              cap_v  [80];
    logic [TN*N-1:0]   cap_y  [80];
    logic [TN-1:0]     cap_s  [80];

    int                wr_cycle;
    logic [3:0]        wr_addr;
    logic [31:0]       wr_data;

    function automatic longint floor_div(input longint num, input longint den);
        longint q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    task automatic ref_lane(input logic [15:0] x, input logic [1:0] m,
                            output logic [15:0] y, output logic s);
        longint xs, p, pr, sum;
        int idx;
        xs = longint'($signed(x));
        s  = 1'b0;
        if (m == 2'd1) begin
            y = (xs < 0) ? 16'h0000 : x;
        end else if (m != 2'd0) begin
            y = x;
        end else begin
            idx = int'(floor_div(xs, longint'(2 ** SEG_SHIFT))) + SEGS / 2;
            if (idx < 0) idx = 0;
            if (idx > SEGS - 1) idx = SEGS - 1;
            p   = xs * longint'(ca[idx]);
            pr  = floor_div(p + longint'(2 ** (FRAC - 1)), longint'(2 ** FRAC));
            sum = pr + longint'(cb[idx]);
            if (sum > YMAX) begin
                y = 16'h7FFF; s = 1'b1;
            end else if (sum < YMIN) begin
                y = 16'h8000; s = 1'b1;
            end else begin
                y = 16'(sum);
            end
        end
    endtask

    task automatic ref_beat(input logic [1:0] m, input logic [TN*N-1:0] xv,
                            output logic [TN*N-1:0] yv, output logic [TN-1:0] sv);
        logic [15:0] ly;
        logic ls;
        yv = '0;
        sv = '0;
        for (int k = 0; k < TN; k++) begin
            ref_lane(xv[k*N +: N], m, ly, ls);
            yv[k*N +: N] = ly;
            sv[k] = ls;
        end
    endtask

    function automatic logic [TN*N-1:0] rand_x();
        logic [TN*N-1:0] v;
        for (int k = 0; k < TN; k++) v[k*N +: N] = 16'($urandom);
        return v;
    endfunction

    task automatic write_coef(input int addr, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.i_coef_we   = 1'b1;
        bus.i_coef_addr = 4'(addr);
        bus.i_coef_data = {a, b};
        @(negedge clk);
        bus.i_coef_we   = 1'b0;
        ca[addr] = int'($signed(a));
        cb[addr] = int'($signed(b));
    endtask

    // Drives nb beats on consecutive cycles and records the outputs seen each cycle.
    task automatic run_stream(input int nb);
        for (int c = 0; c < nb + 6; c++) begin
            @(negedge clk);
            cap_v[c] = bus.o_valid;
            cap_y[c] = bus.o_y;
            cap_s[c] = bus.o_sat;
            if (c < nb) begin
                bus.i_valid = beat_v[c];
                bus.i_mode  = beat_m[c];
                bus.i_x     = beat_x[c];
            end else begin
                bus.i_valid = 1'b0;
                bus.i_mode  = 2'd0;
                bus.i_x     = '0;
            end
            if (c == wr_cycle) begin
                bus.i_coef_we   = 1'b1;
                bus.i_coef_addr = wr_addr;
                bus.i_coef_data = wr_data;
            end else begin
                bus.i_coef_we   = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b expected 0", bus.o_valid);
        end
        vectors++;
        if (bus.o_y !== '0) begin
            miscompares++;
            $display("FAIL reset_y: got %h expected 0", bus.o_y);
        end
        vectors++;
        if (bus.o_sat !== '0) begin
            miscompares++;
            $display("FAIL reset_sat: got %h expected 0", bus.o_sat);
        end
        rst = 1'b0;
    endtask

    task automatic init_table();
        for (int i = 0; i < SEGS; i++) write_coef(i, 16'($urandom), 16'($urandom));
    endtask

    task automatic test_pwl_basic();
        logic [TN*N-1:0] ey;
        logic [TN-1:0] es;
        write_coef(9, 16'h0040, 16'h0080);
        beat_v[0] = 1'b1;
        beat_m[0] = 2'd0;
        beat_x[0] = rand_x();
        beat_x[0][15:0] = 16'h0100;
        ref_beat(beat_m[0], beat_x[0], ey, es);
        run_stream(1);
        vectors++;
        if (cap_v[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early_valid: got %b expected 0", cap_v[3]);
        end
        vectors++;
        if (cap_v[4] !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_valid: got %b expected 1", cap_v[4]);
        end
        vectors++;
        if (cap_y[4][15:0] !== 16'h00C0) begin
            miscompares++;
            $display("FAIL basic_lane0: got %h expected 00c0", cap_y[4][15:0]);
        end
        vectors++;
        if (cap_s[4][0] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_sat0: got %b expected 0", cap_s[4][0]);
        end
        vectors++;
        if (cap_y[4] !== ey || cap_s[4] !== es) begin
            miscompares++;
            $display("FAIL basic_all_lanes: got %h/%h expected %h/%h", cap_y[4], cap_s[4], ey, es);
        end
        vectors++;
        if (cap_v[5] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_single_pulse: got %b expected 0", cap_v[5]);
        end
    endtask

    task automatic test_clamp_sat();
        logic [TN*N-1:0] ey;
        logic [TN-1:0] es;
        write_coef(0, 16'h0100, 16'h0000);
        write_coef(15, 16'h7FFF, 16'h7FFF);
        beat_v[0] = 1'b1;
        beat_m[0] = 2'd0;
        beat_x[0] = rand_x();
        beat_x[0][15:0]  = 16'h8000;
        beat_x[0][31:16] = 16'h7FFF;
        ref_beat(beat_m[0], beat_x[0], ey, es);
        run_stream(1);
        vectors++;
        if (cap_y[4][15:0] !== 16'h8000 || cap_s[4][0] !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_low: got %h/%b expected 8000/0", cap_y[4][15:0], cap_s[4][0]);
        end
        vectors++;
        if (cap_y[4][31:16] !== 16'h7FFF || cap_s[4][1] !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_high: got %h/%b expected 7fff/1", cap_y[4][31:16], cap_s[4][1]);
        end
        vectors++;
        if (cap_y[4] !== ey || cap_s[4] !== es) begin
            miscompares++;
            $display("FAIL clamp_all_lanes: got %h/%h expected %h/%h", cap_y[4], cap_s[4], ey, es);
        end
    endtask

    task automatic test_relu_bypass();
        logic [TN*N-1:0] ey;
        logic [TN-1:0] es;
        for (int i = 0; i < 12; i++) begin
            beat_v[i] = 1'b1;
            beat_m[i] = 2'(i % 4);
            beat_x[i] = rand_x();
        end
        beat_m[0] = 2'd1;
        beat_x[0][15:0]  = 16'hFF00;
        beat_x[0][31:16] = 16'h0123;
        beat_m[1] = 2'd2;
        beat_x[1][15:0]  = 16'hFF00;
        run_stream(12);
        vectors++;
        if (cap_y[4][15:0] !== 16'h0000 || cap_y[4][31:16] !== 16'h0123) begin
            miscompares++;
            $display("FAIL relu_const: got %h %h expected 0000 0123", cap_y[4][15:0], cap_y[4][31:16]);
        end
        vectors++;
        if (cap_y[5][15:0] !== 16'hFF00) begin
            miscompares++;
            $display("FAIL bypass_const: got %h expected ff00", cap_y[5][15:0]);
        end
        for (int i = 0; i < 12; i++) begin
            ref_beat(beat_m[i], beat_x[i], ey, es);
            vectors++;
            if (cap_v[i+4] !== 1'b1 || cap_y[i+4] !== ey || cap_s[i+4] !== es) begin
                miscompares++;
                $display("FAIL mode_mix[%0d] m=%0d: got %b/%h/%h expected 1/%h/%h",
                         i, beat_m[i], cap_v[i+4], cap_y[i+4], cap_s[i+4], ey, es);
            end
        end
    endtask

    task automatic test_streaming();
        logic [TN*N-1:0] ey;
        logic [TN-1:0] es;
        init_table();
        for (int i = 0; i < 20; i++) begin
            beat_v[i] = 1'b1;
            beat_m[i] = 2'd0;
            beat_x[i] = rand_x();
        end
        run_stream(20);
        for (int i = 0; i < 20; i++) begin
            ref_beat(beat_m[i], beat_x[i], ey, es);
            vectors++;
            if (cap_v[i+4] !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_valid[%0d]: got %b expected 1", i, cap_v[i+4]);
            end
            vectors++;
            if (cap_y[i+4] !== ey || cap_s[i+4] !== es) begin
                miscompares++;
                $display("FAIL stream_data[%0d]: got %h/%h expected %h/%h",
                         i, cap_y[i+4], cap_s[i+4], ey, es);
            end
        end
        vectors++;
        if (cap_v[24] !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_tail_valid: got %b expected 0", cap_v[24]);
        end
    endtask

    task automatic test_collision();
        write_coef(9, 16'h0040, 16'h0080);
        for (int i = 0; i < 2; i++) begin
            beat_v[i] = 1'b1;
            beat_m[i] = 2'd0;
            beat_x[i] = '0;
            beat_x[i][15:0] = 16'h0100;
        end
        wr_cycle = 1;
        wr_addr  = 4'd9;
        wr_data  = {16'h0100, 16'h0000};
        run_stream(2);
        wr_cycle = -1;
        ca[9] = 256;
        cb[9] = 0;
        vectors++;
        if (cap_v[4] !== 1'b1 || cap_y[4][15:0] !== 16'h00C0) begin
            miscompares++;
            $display("FAIL collision_old: got %b/%h expected 1/00c0", cap_v[4], cap_y[4][15:0]);
        end
        vectors++;
        if (cap_v[5] !== 1'b1 || cap_y[5][15:0] !== 16'h0100) begin
            miscompares++;
            $display("FAIL collision_new: got %b/%h expected 1/0100", cap_v[5], cap_y[5][15:0]);
        end
    endtask

    task automatic test_reset_midflight();
        logic [TN*N-1:0] ey;
        logic [TN-1:0] es;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.i_mode  = 2'd0;
            bus.i_x     = rand_x();
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_x     = '0;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_y !== '0 || bus.o_sat !== '0) begin
            miscompares++;
            $display("FAIL midflight_reset: got %b/%h/%h expected 0/0/0", bus.o_valid, bus.o_y, bus.o_sat);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.o_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL stale_beat[%0d]: got %b expected 0", c, bus.o_valid);
            end
        end
        beat_v[0] = 1'b1;
        beat_m[0] = 2'd0;
        beat_x[0] = rand_x();
        ref_beat(beat_m[0], beat_x[0], ey, es);
        run_stream(1);
        vectors++;
        if (cap_v[4] !== 1'b1 || cap_y[4] !== ey || cap_s[4] !== es) begin
            miscompares++;
            $display("FAIL post_reset_beat: got %b/%h/%h expected 1/%h/%h",
                     cap_v[4], cap_y[4], cap_s[4], ey, es);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_valid     = 1'b0;
        bus.i_mode      = 2'd0;
        bus.i_x         = '0;
        bus.i_coef_we   = 1'b0;
        bus.i_coef_addr = '0;
        bus.i_coef_data = '0;
        wr_cycle        = -1;
        wr_addr         = '0;
        wr_data         = '0;
        vectors         = 0;
        miscompares     = 0;

        test_reset();
        init_table();
        test_pwl_basic();
        test_clamp_sat();
        test_relu_bypass();
        test_streaming();
        test_collision();
        test_reset_midflight();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
